core_inst_seq: RTL and testbench
================================

Name: core_inst_seq

Overview:
- Instruction sequencer driving the 34-bit instruction bus of the accelerator core.
- For each kernel position it issues, in order:
  - weight fetch from xmem into L0
  - weight load into the PE array
  - activation fetch
  - execute
  - output-FIFO drain into pmem, with accumulate from the second kernel position onward
- Sits between the testbench/host start pulse and the core; consumes the core's ofifo_valid.

Parameters:
- ROW, 8, PE array rows / L0 rows written per weight tile.
- COL, 8, PE array columns; sets drain wait.
- N_ACT, 36, activation vectors per kernel position (also outputs per position).
- N_KIJ, 9, kernel positions accumulated.
- W_BASE, 0, xmem base of weights; tile k at W_BASE + k*ROW.
- A_BASE, 1024, xmem base of activations.
- P_BASE, 0, pmem base of outputs.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse, begins a run when idle
- ofifo_valid  input  1  core output FIFO has a row available
- inst  output  34  core instruction; field layout:
  - [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at end of run
- err  output  1  watchdog error flag (see Optional Feature)

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- IDLE instruction = 34'h1_800C_0000:
  - all CEN/WEN high (SRAMs are active-low)
  - all other bits 0
- Reset, including mid-run:
  - state=IDLE, inst=IDLE, busy=0, done=0, err=0
  - all counters 0
  - no partial transfer is completed.
- start is accepted only in IDLE. start while busy is ignored. kij counter resets to 0 on accept.
- States per kij, in order:
  - W_FETCH, ROW+1 cycles, cycle t:
    - t<ROW: CEN_xmem=0, WEN_xmem=1, A_xmem=W_BASE+kij*ROW+t
    - t>=1: l0_wr=1 (SRAM read latency 1)
  - W_LOAD, ROW cycles: l0_rd=1, load=1.
  - W_DRAIN, ROW+COL cycles: IDLE instruction.
  - A_FETCH, N_ACT+1 cycles: same pattern as W_FETCH with A_xmem=A_BASE+t and length N_ACT.
  - EXEC, N_ACT cycles: l0_rd=1, execute=1.
  - OUT, two phases per output j (0..N_ACT-1):
    - RD phase: waits (IDLE instruction) while ofifo_valid=0. When ofifo_valid=1, presents:
      - ofifo_rd=1
      - if kij>0: CEN_pmem=0, WEN_pmem=1, A_pmem=P_BASE+j
    - WR phase, next cycle: CEN_pmem=0, WEN_pmem=0, A_pmem=P_BASE+j, acc=(kij!=0).
  - After output N_ACT-1:
    - if kij<N_KIJ-1: kij++ and go to W_FETCH
    - else: go to DONE.
- DONE: one cycle; done=1, busy falls on the next cycle, return to IDLE.
- Address arithmetic is 11-bit and wraps modulo 2048, with no error.
- ififo_wr and ififo_rd are always 0.
- Never assert load and execute in the same cycle.
- Never assert WEN_xmem=0.

Optional Feature:
- Macro: CORE_INST_SEQ_WATCHDOG_EN.
- Enabled:
  - An 8-bit counter increments on each OUT RD-phase cycle with ofifo_valid=0 and clears when ofifo_valid=1.
  - At 255: err=1 (sticky until reset), inst=IDLE, go to DONE (done pulses).
- Disabled: err tied 0; OUT waits indefinitely.

Test Plan:
1. ROW=8, N_ACT=4, N_KIJ=1, ofifo_valid tied 1:
   - xmem reads of addrs 0..7 precede l0_wr by one cycle
   - 8 load cycles
   - 16 idle cycles
   - reads of 1024..1027
   - 4 execute cycles
   - pmem writes of addrs 0..3 with acc=0 and no pmem reads
   - done pulse exactly once.
2. N_KIJ=2:
   - second pass fetches weights at 8..15
   - OUT issues a pmem read at j then a write at j with acc=1 for j=0..3.
3. ofifo_valid held low 10 cycles at OUT j=2:
   - inst stays IDLE for 10 cycles
   - resumes with ofifo_rd at j=2
   - no address skipped.
4. Reset asserted mid-EXEC:
   - next cycle inst=34'h1_800C_0000, busy=0
   - a fresh start replays from W_FETCH kij=0.
5. start pulsed during busy: no restart; done count equals 1.
6. Watchdog:
   - with CORE_INST_SEQ_WATCHDOG_EN, ofifo_valid stuck 0 in OUT: err=1 after 255 cycles, done pulse.
   - without the macro: err stays 0 and the sequencer waits indefinitely.

Source files
------------

// File: rtl/core_inst_seq.sv
// core_inst_seq: instruction sequencer for the accelerator core (weight fetch/load, activation fetch, execute, output drain)
// Ports:
//   clk         clock
//   reset       synchronous active-high reset
//   start       one-cycle pulse, begins a run when idle
//   ofifo_valid core output FIFO has a row available
//   inst[33:0]  registered core instruction
//   busy        high from accepted start until done
//   done        one-cycle pulse at end of run
//   err         watchdog error flag (CORE_INST_SEQ_WATCHDOG_EN), else tied 0
// All outputs are registered decodes of the current state, so they trail the state register by one cycle.
module core_inst_seq #(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int N_ACT  = 36,
    parameter int N_KIJ  = 9,
    parameter int W_BASE = 0,
    parameter int A_BASE = 1024,
    parameter int P_BASE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [3:0] {S_IDLE, S_WF, S_WL, S_WD, S_AF, S_EX, S_ORD, S_OWR, S_DONE} state_t;
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
    localparam logic [15:0] ROW_C  = 16'(ROW);
    localparam logic [15:0] RC_C   = 16'(ROW + COL);
    localparam logic [15:0] NACT_C = 16'(N_ACT);
    localparam logic [15:0] NKIJ_C = 16'(N_KIJ);
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, j_q, j_d, kij_q, kij_d;
    logic [33:0] inst_q, inst_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        wd_trip;
    logic [10:0] w_addr, a_addr, p_addr;
    // 11-bit address arithmetic wraps modulo 2048
    assign w_addr = 11'(W_BASE + 32'(kij_q) * ROW + 32'(cnt_q));
    assign a_addr = 11'(A_BASE + 32'(cnt_q));
    assign p_addr = 11'(P_BASE + 32'(j_q));
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            j_q     <= '0;
            kij_q   <= '0;
            inst_q  <= IDLE_INST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            kij_q   <= kij_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        j_d     = j_q;
        kij_d   = kij_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_WF;
                    kij_d   = '0;
                    j_d     = '0;
                end
            end
            S_WF: if (cnt_q == ROW_C) begin state_d = S_WL; cnt_d = '0; end
            S_WL: if (cnt_q == ROW_C - 16'd1) begin state_d = S_WD; cnt_d = '0; end
            S_WD: if (cnt_q == RC_C - 16'd1) begin state_d = S_AF; cnt_d = '0; end
            S_AF: if (cnt_q == NACT_C) begin state_d = S_EX; cnt_d = '0; end
            S_EX: if (cnt_q == NACT_C - 16'd1) begin state_d = S_ORD; cnt_d = '0; j_d = '0; end
            S_ORD: begin
                cnt_d = '0;
                state_d = ofifo_valid ? S_OWR : (wd_trip ? S_DONE : S_ORD);
            end
            S_OWR: begin
                cnt_d = '0;
                if (j_q == NACT_C - 16'd1) begin
                    j_d = '0;
                    if (kij_q == NKIJ_C - 16'd1) state_d = S_DONE;
                    else begin
                        kij_d   = kij_q + 16'd1;
                        state_d = S_WF;
                    end
                end else begin
                    j_d     = j_q + 16'd1;
                    state_d = S_ORD;
                end
            end
            S_DONE: begin state_d = S_IDLE; cnt_d = '0; end
            default: state_d = S_IDLE;
        endcase
    end
    always_comb begin
        inst_d = IDLE_INST;
        busy_d = state_q != S_IDLE;
        done_d = state_q == S_DONE;
        case (state_q)
            // SRAM read latency is one cycle, so l0_wr trails each xmem read by one cycle
            S_WF, S_AF: begin
                if (cnt_q < (state_q == S_WF ? ROW_C : NACT_C)) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = state_q == S_WF ? w_addr : a_addr;
                end
                inst_d[2] = cnt_q != '0;
            end
            S_WL: begin inst_d[3] = 1'b1; inst_d[0] = 1'b1; end
            S_EX: begin inst_d[3] = 1'b1; inst_d[1] = 1'b1; end
            // from the second kernel position the partial sum is read back before the accumulate write
            S_ORD: if (ofifo_valid) begin
                inst_d[6] = 1'b1;
                if (kij_q != '0) begin
                    inst_d[32]    = 1'b0;
                    inst_d[30:20] = p_addr;
                end
            end
            S_OWR: begin
                inst_d[33]    = kij_q != '0;
                inst_d[32]    = 1'b0;
                inst_d[31]    = 1'b0;
                inst_d[30:20] = p_addr;
            end
            default: ;
        endcase
    end
`ifdef CORE_INST_SEQ_WATCHDOG_EN
    logic [7:0] wd_q, wd_d;
    logic       err_q, err_d;
    // trips on the 255th consecutive stalled read-phase cycle
    assign wd_trip = state_q == S_ORD && !ofifo_valid && wd_q == 8'd254;
    always_comb begin
        wd_d  = (state_q == S_ORD && !ofifo_valid) ? wd_q + 8'd1 : 8'd0;
        err_d = err_q | wd_trip;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign wd_trip = 1'b0;
    assign err     = 1'b0;
`endif
    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_core_inst_seq.sv
// tb_core_inst_seq: directed self-checking bench for core_inst_seq (ROW=8, COL=8, N_ACT=4, N_KIJ=2)
module tb_core_inst_seq;
    localparam logic [33:0] IDL = 34'h1_800C_0000;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, ofifo_valid = 1'b1;
    logic [33:0] inst;
    logic        busy, done, err;
    int          checks = 0, passes = 0, fails = 0, done_cnt = 0, d0 = 0;

    core_inst_seq #(.ROW(8), .COL(8), .N_ACT(4), .N_KIJ(2), .W_BASE(0), .A_BASE(1024), .P_BASE(0)) dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] fetch(input int t, input int base, input int len);
        logic [33:0] r;
        r = IDL;
        if (t < len) begin
            r[19]   = 1'b0;
            r[17:7] = 11'(base + t);
        end
        r[2] = t >= 1;
        return r;
    endfunction

    function automatic logic [33:0] ld();
        logic [33:0] r;
        r = IDL;
        r[3] = 1'b1;
        r[0] = 1'b1;
        return r;
    endfunction

    function automatic logic [33:0] ex();
        logic [33:0] r;
        r = IDL;
        r[3] = 1'b1;
        r[1] = 1'b1;
        return r;
    endfunction

    function automatic logic [33:0] ord(input int k, input int j);
        logic [33:0] r;
        r = IDL;
        r[6] = 1'b1;
        if (k > 0) begin
            r[32]    = 1'b0;
            r[30:20] = 11'(j);
        end
        return r;
    endfunction

    function automatic logic [33:0] owr(input int k, input int j);
        logic [33:0] r;
        r = IDL;
        r[33]    = k != 0;
        r[32]    = 1'b0;
        r[31]    = 1'b0;
        r[30:20] = 11'(j);
        return r;
    endfunction

    task automatic step(input string tag, input logic [33:0] exp);
        tick;
        chk(tag, inst, exp);
    endtask

    task automatic pre_out(input int k, input bit poke, input int n_exec);
        for (int t = 0; t <= 8; t++) step($sformatf("wfetch k%0d t%0d", k, t), fetch(t, k * 8, 8));
        for (int t = 0; t < 8; t++) begin
            if (poke && t == 2) start = 1'b1;
            step($sformatf("wload k%0d t%0d", k, t), ld());
            start = 1'b0;
        end
        for (int t = 0; t < 16; t++) step($sformatf("wdrain k%0d t%0d", k, t), IDL);
        for (int t = 0; t <= 4; t++) step($sformatf("afetch k%0d t%0d", k, t), fetch(t, 1024, 4));
        for (int t = 0; t < n_exec; t++) step($sformatf("exec k%0d t%0d", k, t), ex());
    endtask

    task automatic out_phase(input int k, input int stall_j);
        for (int j = 0; j < 4; j++) begin
            if (j == stall_j) begin
                ofifo_valid = 1'b0;
                for (int s = 0; s < 10; s++) step($sformatf("stall k%0d s%0d", k, s), IDL);
                ofifo_valid = 1'b1;
            end
            step($sformatf("ofifo_rd k%0d j%0d", k, j), ord(k, j));
            step($sformatf("pmem_wr k%0d j%0d", k, j), owr(k, j));
        end
    endtask

    task automatic finish_run(input string tag);
        chkb({tag, " done_low"}, done, 1'b0);
        tick;
        chkb({tag, " done_pulse"}, done, 1'b1);
        chkb({tag, " busy_at_done"}, busy, 1'b1);
        tick;
        chkb({tag, " busy_fall"}, busy, 1'b0);
        chk({tag, " idle_inst"}, inst, IDL);
        tick;
        tick;
        chkn({tag, " done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        repeat (3) tick;
        chk("rst inst", inst, IDL);
        chkb("rst busy", busy, 1'b0);
        chkb("rst done", done, 1'b0);
        chkb("rst err", err, 1'b0);
        reset = 1'b0;
        tick;
        chk("idle inst", inst, IDL);

        // two kernel positions, start poked mid-run, stall at second pass j=2
        d0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        pre_out(0, 1'b1, 4);
        chkb("busy in run", busy, 1'b1);
        out_phase(0, -1);
        pre_out(1, 1'b0, 4);
        out_phase(1, 2);
        finish_run("run1");

        // reset during EXEC, then replay from the first weight fetch
        start = 1'b1;
        tick;
        start = 1'b0;
        pre_out(0, 1'b0, 2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midrst inst", inst, IDL);
        chkb("midrst busy", busy, 1'b0);
        chkb("midrst done", done, 1'b0);
        tick;
        chk("midrst hold", inst, IDL);
        d0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        pre_out(0, 1'b0, 4);
        out_phase(0, -1);
        pre_out(1, 1'b0, 4);
        out_phase(1, -1);
        finish_run("run2");

        // output FIFO never becomes valid
        start = 1'b1;
        tick;
        start = 1'b0;
        pre_out(0, 1'b0, 4);
        ofifo_valid = 1'b0;
`ifdef CORE_INST_SEQ_WATCHDOG_EN
        d0 = done_cnt;
        repeat (254) tick;
        chkb("wd err before", err, 1'b0);
        chk("wd inst idle", inst, IDL);
        tick;
        chkb("wd err set", err, 1'b1);
        chk("wd inst trip", inst, IDL);
        tick;
        chkb("wd done", done, 1'b1);
        tick;
        chkb("wd busy fall", busy, 1'b0);
        chkb("wd err sticky", err, 1'b1);
        chkn("wd done once", done_cnt - d0, 1);
        ofifo_valid = 1'b1;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chkb("wd err cleared", err, 1'b0);
`else
        repeat (300) tick;
        chkb("nowd err", err, 1'b0);
        chkb("nowd busy", busy, 1'b1);
        chk("nowd inst", inst, IDL);
        ofifo_valid = 1'b1;
        step("nowd resume", ord(0, 0));
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chkb("nowd rst busy", busy, 1'b0);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
